// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition evaluation
// and the E->M pipeline register.
module execute_stage #(
    parameter int unsigned WORD  = 64,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_ifun,
    input  logic [WORD-1:0] E_valC,
    input  logic [WORD-1:0] E_valA,
    input  logic [WORD-1:0] E_valB,
    input  logic [3:0]      E_dstE,
    input  logic [3:0]      E_dstM,
    input  logic            set_cc_en,
    input  logic            M_bubble,
    output logic [WORD-1:0] e_valE,
    output logic [3:0]      e_dstE,
    output logic            e_Cnd,
    output logic [2:0]      M_stat,
    output logic [3:0]      M_icode,
    output logic            M_Cnd,
    output logic [WORD-1:0] M_valE,
    output logic [WORD-1:0] M_valA,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM,
    output logic [2:0]      cc_out
);

    localparam logic [2:0]      STAT_AOK = 3'd1;
    localparam logic [3:0]      I_NOP    = 4'h1;
    localparam logic [3:0]      I_CMOV   = 4'h2;
    localparam logic [3:0]      I_OPQ    = 4'h6;
    localparam logic [3:0]      I_JXX    = 4'h7;
    localparam logic [1:0]      F_ADD    = 2'd0;
    localparam logic [1:0]      F_SUB    = 2'd1;
    localparam logic [1:0]      F_AND    = 2'd2;
    localparam logic [1:0]      F_XOR    = 2'd3;
    localparam logic [WORD-1:0] EIGHT    = WORD'(64'd8);

    logic [WORD-1:0] alu_a_s, alu_b_s, alu_res_s;
    logic [1:0]      alu_fun_s;
    logic            alu_zero_s, of_s, cond_s, cc_we_s;
    logic [2:0]      cc_d, cc_q;

    logic [2:0]      m_stat_d, m_stat_q;
    logic [3:0]      m_icode_d, m_icode_q, m_dste_d, m_dste_q, m_dstm_d, m_dstm_q;
    logic            m_cnd_d, m_cnd_q;
    logic [WORD-1:0] m_vale_d, m_vale_q, m_vala_d, m_vala_q;

    // ALU operand and function selection by instruction class
    always_comb begin
        alu_a_s    = '0;
        alu_b_s    = '0;
        alu_fun_s  = F_ADD;
        alu_zero_s = 1'b0;
        case (E_icode)
            4'h2:       alu_a_s = E_valA;
            4'h3:       alu_a_s = E_valC;
            4'h4, 4'h5: begin alu_a_s = E_valC; alu_b_s = E_valB; end
            4'h6: begin
                alu_a_s = E_valA;
                alu_b_s = E_valB;
                if (E_ifun > 4'd3) begin
                    alu_zero_s = 1'b1;
                end else begin
                    alu_fun_s = E_ifun[1:0];
                end
            end
            4'h8, 4'hA: begin alu_a_s = EIGHT; alu_b_s = E_valB; alu_fun_s = F_SUB; end
            4'h9, 4'hB: begin alu_a_s = EIGHT; alu_b_s = E_valB; end
            default:    alu_zero_s = 1'b1;
        endcase
    end

    // ALU datapath and overflow detection
    always_comb begin
        alu_res_s = '0;
        of_s      = 1'b0;
        if (alu_zero_s) begin
            alu_res_s = '0;
        end else begin
            case (alu_fun_s)
                F_ADD: begin
                    alu_res_s = alu_b_s + alu_a_s;
                    of_s = (alu_a_s[WORD-1] == alu_b_s[WORD-1]) &&
                           (alu_res_s[WORD-1] != alu_b_s[WORD-1]);
                end
                F_SUB: begin
                    alu_res_s = alu_b_s - alu_a_s;
                    of_s = (alu_a_s[WORD-1] != alu_b_s[WORD-1]) &&
                           (alu_res_s[WORD-1] != alu_b_s[WORD-1]);
                end
                F_AND:   alu_res_s = alu_b_s & alu_a_s;
                F_XOR:   alu_res_s = alu_b_s ^ alu_a_s;
                default: alu_res_s = '0;
            endcase
        end
    end

    // Condition evaluation against the pre-update condition codes {ZF,SF,OF}
    always_comb begin
        case (E_ifun)
            4'h0:    cond_s = 1'b1;
            4'h1:    cond_s = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2:    cond_s = cc_q[1] ^ cc_q[0];
            4'h3:    cond_s = cc_q[2];
            4'h4:    cond_s = ~cc_q[2];
            4'h5:    cond_s = ~(cc_q[1] ^ cc_q[0]);
            4'h6:    cond_s = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: cond_s = 1'b0;
        endcase
    end

    assign e_valE  = alu_res_s;
    assign e_Cnd   = ((E_icode == I_CMOV) || (E_icode == I_JXX)) ? cond_s : 1'b0;
    assign e_dstE  = ((E_icode == I_CMOV) && !e_Cnd) ? RNONE : E_dstE;
    // A faulting or squashed OPq must never disturb the flags
    assign cc_we_s = (E_icode == I_OPQ) && set_cc_en && (E_stat == STAT_AOK);
    assign cc_d    = cc_we_s ? {(alu_res_s == '0), alu_res_s[WORD-1], of_s} : cc_q;

    // Next M-register contents; a bubble loads the nop pattern
    always_comb begin
        if (M_bubble) begin
            m_stat_d  = STAT_AOK;
            m_icode_d = I_NOP;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = RNONE;
            m_dstm_d  = RNONE;
        end else begin
            m_stat_d  = E_stat;
            m_icode_d = E_icode;
            m_cnd_d   = e_Cnd;
            m_vale_d  = e_valE;
            m_vala_d  = E_valA;
            m_dste_d  = e_dstE;
            m_dstm_d  = E_dstM;
        end
    end

    // Condition-code and E->M pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q      <= 3'b100;
            m_stat_q  <= STAT_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            cc_q      <= cc_d;
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign cc_out  = cc_q;
    assign M_stat  = m_stat_q;
    assign M_icode = m_icode_q;
    assign M_Cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Y86-64 pipelined execute stage. It sits directly downstream of the decode stage and consumes its valA/valB together with the E pipeline-register fields. It contains the ALU, the condition-code register (ZF/SF/OF) and the condition evaluator for cmovXX/jXX, and it drives the E->M pipeline register. It also provides the combinational e_valE/e_dstE/e_Cnd outputs used by forwarding and by the branch-mispredict logic.

Parameters:
WORD, 64, datapath width.
RNONE, 4'hF, register ID meaning "no register".

Ports:
clk  in  1  pipeline clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
E_stat  in  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
E_icode  in  4  instruction code.
E_ifun  in  4  function code (ALU op or condition).
E_valC  in  WORD  constant word.
E_valA  in  WORD  operand A from decode.
E_valB  in  WORD  operand B from decode.
E_dstE  in  4  destination for valE.
E_dstM  in  4  destination for valM.
set_cc_en  in  1  CC write enable; low while M/W carries an exception.
M_bubble  in  1  inject a nop into the M register this cycle.
e_valE  out  WORD  combinational ALU result.
e_dstE  out  4  combinational effective dstE after cmov squash.
e_Cnd  out  1  combinational condition result.
M_stat  out  3  registered.
M_icode  out  4  registered.
M_Cnd  out  1  registered.
M_valE  out  WORD  registered.
M_valA  out  WORD  registered.
M_dstE  out  4  registered.
M_dstM  out  4  registered.
cc_out  out  3  {ZF,SF,OF}, registered.

Behaviour:
- Reset (async, rst_n=0):
  - M_stat=1, M_icode=4'h1 (nop), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
  - cc_out={1,0,0}.
  - Reset asserted mid-operation discards the in-flight instruction immediately.
- ALU operand selection, by icode:
  - 2 (cmov): valE = 0+valA.
  - 3 (irmovq): valE = 0+valC.
  - 4/5 (rmmovq/mrmovq): valE = valB+valC.
  - 6 (OPq): valE = valB OP valA.
  - 8/A (call/pushq): valE = valB-8.
  - 9/B (ret/popq): valE = valB+8.
  - All other icodes: valE = 0.
- ALU function: ifun applies only for icode 6 (0=add, 1=sub valB-valA, 2=and, 3=xor); ifun>3 yields result 0. Every other icode uses add. Arithmetic is modulo 2^64 with no saturation.
- Flags, computed from the icode-6 result:
  - ZF = (result==0); SF = result[63].
  - OF for add: sign(A)==sign(B) and sign(res)!=sign(B).
  - OF for sub: sign(B)!=sign(A) and sign(res)!=sign(B).
  - OF for and/xor: 0.
- CC register update: at posedge, only when E_icode==6 and set_cc_en==1 and E_stat==AOK. Otherwise the CC holds.
- Condition evaluation: uses the current (pre-update) cc_out, combinational on E_ifun:
  - 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: ~ZF.
  - 5 ge: ~(SF^OF).
  - 6 g: ~(SF^OF)&~ZF.
  - 7–F: 0.
  - e_Cnd is meaningful only for icode 2/7 and is 0 for other icodes.
- e_dstE: equals RNONE when icode==2 and e_Cnd==0; otherwise equals E_dstE.
- M register: latency 1. At each posedge the register loads {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}. The M register has no stall input.
- M_bubble=1: at that posedge the register loads reset values instead (stat=AOK, icode=nop, dst=RNONE). The CC update is independent of M_bubble.
- Simultaneous OPq followed by a dependent jXX in the next cycle: the jXX sees the CC written by the OPq; there is no bypass within the same cycle.
- CC writes are suppressed for non-AOK E_stat, so a faulting OPq never alters the CC.

Test Plan:
- Reset, then release rst_n -> M_icode=1, M_dstE=F, cc_out=3'b100, and these values hold while inputs are idle.
- OPq sub with valB=5, valA=5, dstE=3 -> e_valE=0; next edge M_valE=0, M_dstE=3, cc_out=3'b100. Repeat with valB=3, valA=5 -> valE=0xFFFF_FFFF_FFFF_FFFE, cc_out=3'b010.
- OPq add with valB=valA=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, cc_out=3'b011 (SF=1, OF=1).
- Starting from cc_out=3'b010, cmovle (ifun=1) with dstE=2 -> e_Cnd=1, e_dstE=2. Then cmove (ifun=3) -> e_Cnd=0, e_dstE=F, M_dstE=F.
- pushq with valB=0x100 -> e_valE=0xF8. popq with valB=0x100 -> e_valE=0x108. Neither changes the CC.
- OPq with set_cc_en=0, or with E_stat=3 -> cc_out is unchanged. An OPq with M_bubble=1 -> M_icode=1 and M_dstE=F, but the CC still updates. Asserting rst_n=0 mid-cycle clears M and the CC asynchronously without waiting for a clock edge.
